// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch (imem) and load/store (dmem).
// Default build: dmem priority with an imem starvation bound; define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] imem_addr_i,
  input  logic [3:0]  imem_rmask_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_resp_o,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_rmask_i,
  input  logic [3:0]  dmem_wmask_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_resp_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_rmask_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_resp_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        imem_req, dmem_req, dmem_store, pick_d;
  logic        take_i, take_d;
  logic [31:0] addr_nxt, wdata_nxt;
  logic [3:0]  rmask_nxt, wmask_nxt;

  assign imem_req   = |imem_rmask_i;
  assign dmem_store = |dmem_wmask_i;
  assign dmem_req   = (|dmem_rmask_i) | dmem_store;

`ifdef MEM_ARB_RR_EN
  // rr_last: 1 = dmem held the port last, 0 = imem (reset value)
  logic rr_last;

  assign pick_d = dmem_req && !(imem_req && rr_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     rr_last <= 1'b0;
    else if (take_d) rr_last <= 1'b1;
    else if (take_i) rr_last <= 1'b0;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  assign pick_d = dmem_req && !(imem_req && (starve_cnt == STARVE_LIM));

  // Counts dmem wins taken over a waiting fetch; saturates at the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                           starve_cnt <= 4'd0;
    else if (take_i)                                       starve_cnt <= 4'd0;
    else if (take_d && imem_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      mem_addr_o  <= 32'd0;
      mem_rmask_o <= 4'd0;
      mem_wmask_o <= 4'd0;
      mem_wdata_o <= 32'd0;
    end else begin
      state       <= state_nxt;
      mem_addr_o  <= addr_nxt;
      mem_rmask_o <= rmask_nxt;
      mem_wmask_o <= wmask_nxt;
      mem_wdata_o <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr_o;
    rmask_nxt = mem_rmask_o;
    wmask_nxt = mem_wmask_o;
    wdata_nxt = mem_wdata_o;
    take_i    = 1'b0;
    take_d    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          // A store wins over a simultaneous load mask
          take_d    = 1'b1;
          state_nxt = BUSY_D;
          addr_nxt  = {dmem_addr_i[31:2], 2'b00};
          rmask_nxt = dmem_store ? 4'd0 : dmem_rmask_i;
          wmask_nxt = dmem_wmask_i;
          wdata_nxt = dmem_store ? dmem_wdata_i : 32'd0;
        end else if (imem_req) begin
          take_i    = 1'b1;
          state_nxt = BUSY_I;
          addr_nxt  = {imem_addr_i[31:2], 2'b00};
          rmask_nxt = imem_rmask_i;
          wmask_nxt = 4'd0;
          wdata_nxt = 32'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp_i) begin
          state_nxt = IDLE;
          addr_nxt  = 32'd0;
          rmask_nxt = 4'd0;
          wmask_nxt = 4'd0;
          wdata_nxt = 32'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = 32'd0;
        rmask_nxt = 4'd0;
        wmask_nxt = 4'd0;
        wdata_nxt = 32'd0;
      end
    endcase
  end

  assign grant_o      = {state == BUSY_D, state == BUSY_I};
  assign imem_resp_o  = (state == BUSY_I) && mem_resp_i;
  assign dmem_resp_o  = (state == BUSY_D) && mem_resp_i;
  assign imem_rdata_o = imem_resp_o ? mem_rdata_i : 32'd0;
  assign dmem_rdata_o = dmem_resp_o ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Honors MEM_ARB_RR_EN the same way as the design.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk_i, rst_ni;
  logic [31:0] imem_addr_i, imem_rdata_o;
  logic [3:0]  imem_rmask_i;
  logic        imem_resp_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  dmem_rmask_i, dmem_wmask_i;
  logic        dmem_resp_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_rmask_o, mem_wmask_o;
  logic        mem_resp_i;
  logic [1:0]  grant_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_addr_i(imem_addr_i), .imem_rmask_i(imem_rmask_i),
    .imem_rdata_o(imem_rdata_o), .imem_resp_o(imem_resp_o),
    .dmem_addr_i(dmem_addr_i), .dmem_rmask_i(dmem_rmask_i),
    .dmem_wmask_i(dmem_wmask_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o), .dmem_resp_o(dmem_resp_o),
    .mem_addr_o(mem_addr_o), .mem_rmask_o(mem_rmask_o),
    .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
    .grant_o(grant_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    imem_addr_i = 0; imem_rmask_i = 0;
    dmem_addr_i = 0; dmem_rmask_i = 0; dmem_wmask_i = 0; dmem_wdata_i = 0;
    mem_rdata_i = 0; mem_resp_i = 0;
  endtask

  // Leaves the bench just after a rising edge with the DUT idle
  task automatic do_reset();
    clear_inputs();
    #2 rst_ni = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    n_cmp++;
    if ({grant_o, mem_addr_o, mem_rmask_o, mem_wmask_o, mem_wdata_o, imem_resp_o, dmem_resp_o,
         imem_rdata_o, dmem_rdata_o} !== '0) begin
      n_err++; $display("FAIL reset_state grant=%b addr=%h rmask=%h wmask=%h", grant_o, mem_addr_o,
                        mem_rmask_o, mem_wmask_o);
    end
    @(posedge clk_i); #1;
    dmem_addr_i = 32'h2000_0010; dmem_rmask_i = 4'hF;
    @(posedge clk_i); #1;
    n_cmp++;
    if (grant_o !== 2'b10) begin n_err++; $display("FAIL reset_pre_busy_d grant=%b want=10", grant_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({grant_o, mem_addr_o, mem_rmask_o} !== '0) begin
      n_err++; $display("FAIL reset_async_clear grant=%b addr=%h rmask=%h want 0", grant_o, mem_addr_o, mem_rmask_o);
    end
    clear_inputs();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({grant_o, imem_resp_o, dmem_resp_o, dmem_rdata_o, imem_rdata_o, mem_addr_o} !== '0) begin
        n_err++; $display("FAIL reset_no_resp c=%0d grant=%b iresp=%b dresp=%b drdata=%h", c, grant_o,
                          imem_resp_o, dmem_resp_o, dmem_rdata_o);
      end
    end
    @(posedge clk_i); #1;
    mem_resp_i = 1'b0;
  endtask

  task automatic test_lone_fetch();
    imem_addr_i = 32'h1000_0006; imem_rmask_i = 4'hF;
    @(negedge clk_i);
    n_cmp++;
    if (grant_o !== 2'b00 || mem_rmask_o !== 4'h0) begin
      n_err++; $display("FAIL fetch_latency grant=%b rmask=%h want 00/0", grant_o, mem_rmask_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if (mem_addr_o !== 32'h1000_0004 || mem_rmask_o !== 4'hF || mem_wmask_o !== 4'h0 || grant_o !== 2'b01) begin
      n_err++; $display("FAIL fetch_issue addr=%h rmask=%h wmask=%h grant=%b want 10000004/F/0/01",
                        mem_addr_o, mem_rmask_o, mem_wmask_o, grant_o);
    end
    mem_resp_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (imem_resp_o !== 1'b1 || imem_rdata_o !== 32'hDEAD_BEEF || dmem_resp_o !== 1'b0 || dmem_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL fetch_resp iresp=%b irdata=%h dresp=%b drdata=%h want 1/DEADBEEF/0/0",
                        imem_resp_o, imem_rdata_o, dmem_resp_o, dmem_rdata_o);
    end
    @(posedge clk_i); #1;
    mem_resp_i = 1'b0; imem_rmask_i = 4'h0;
    @(negedge clk_i);
    n_cmp++;
    if (grant_o !== 2'b00 || mem_addr_o !== 32'h0 || imem_resp_o !== 1'b0) begin
      n_err++; $display("FAIL fetch_release grant=%b addr=%h iresp=%b want 00/0/0", grant_o, mem_addr_o, imem_resp_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_store_byte();
    int dpulses = 0;
    int ipulses = 0;
    dmem_addr_i = 32'h3000_0002; dmem_wmask_i = 4'h4; dmem_wdata_i = 32'h00AB_0000;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if (mem_wmask_o !== 4'h4 || mem_rmask_o !== 4'h0 || mem_wdata_o !== 32'h00AB_0000 ||
        mem_addr_o !== 32'h3000_0000 || grant_o !== 2'b10) begin
      n_err++; $display("FAIL store_issue wmask=%h rmask=%h wdata=%h addr=%h grant=%b", mem_wmask_o,
                        mem_rmask_o, mem_wdata_o, mem_addr_o, grant_o);
    end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk_i);
      mem_resp_i = (c == 2);
      if (c == 3) begin dmem_wmask_i = 4'h0; dmem_wdata_i = 32'h0; end
      #1;
      if (dmem_resp_o === 1'b1) dpulses++;
      if (imem_resp_o !== 1'b0) ipulses++;
    end
    n_cmp++;
    if (dpulses != 1 || ipulses != 0) begin
      n_err++; $display("FAIL store_resp_pulses dmem=%0d imem=%0d want 1/0", dpulses, ipulses);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_spurious_resp();
    mem_resp_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({grant_o, imem_resp_o, dmem_resp_o, imem_rdata_o, dmem_rdata_o, mem_rmask_o} !== '0) begin
        n_err++; $display("FAIL spurious_resp c=%0d grant=%b iresp=%b dresp=%b", c, grant_o, imem_resp_o, dmem_resp_o);
      end
    end
    @(posedge clk_i); #1;
    mem_resp_i = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] want;
    int idx;
    do_reset();
    imem_addr_i = 32'h0000_0100; imem_rmask_i = 4'hF;
    dmem_addr_i = 32'h0000_8000; dmem_rmask_i = 4'hF;
    mem_resp_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (c % 2 == 0) want = 2'b00;
      else begin
        idx = (c - 1) / 2;
`ifdef MEM_ARB_RR_EN
        want = (idx % 2 == 0) ? 2'b10 : 2'b01;
`else
        want = (idx % (STARVE_MAX + 1) == STARVE_MAX) ? 2'b01 : 2'b10;
`endif
      end
      n_cmp++;
      if (grant_o !== want || {dmem_resp_o, imem_resp_o} !== want) begin
        n_err++; $display("FAIL contention c=%0d grant=%b resp=%b%b want %b", c, grant_o, dmem_resp_o, imem_resp_o, want);
      end
    end
    imem_rmask_i = 4'h0; dmem_rmask_i = 4'h0;
    @(posedge clk_i); #1;
    mem_resp_i = 1'b0;
  endtask

  // Randomized traffic; the model tracks pending requests and decides ownership per transaction
  task automatic test_random();
    bit          i_pend = 0, d_pend = 0;
    int          cnt_m = 0, i_wait = 0, lat, kind;
    bit          last_d = 0, pick_d;
    logic [31:0] rd, exp_addr;
    logic [3:0]  exp_rm, exp_wm;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      if (!i_pend && ($urandom_range(0, 1) == 1)) begin
        i_pend = 1; imem_addr_i = $urandom; imem_rmask_i = 4'($urandom_range(1, 15));
      end
      if (!d_pend && ($urandom_range(0, 1) == 1)) begin
        d_pend = 1; kind = $urandom_range(0, 2);
        dmem_addr_i = $urandom; dmem_wdata_i = $urandom;
        dmem_rmask_i = (kind != 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        dmem_wmask_i = (kind != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1; imem_addr_i = $urandom; imem_rmask_i = 4'hF;
      end
`ifdef MEM_ARB_RR_EN
      pick_d = d_pend && !(i_pend && last_d);
`else
      pick_d = d_pend && !(i_pend && cnt_m >= STARVE_MAX);
`endif
      if (pick_d) begin
        exp_addr = dmem_addr_i & ~32'h3;
        exp_wm = dmem_wmask_i;
        exp_rm = (dmem_wmask_i != 0) ? 4'h0 : dmem_rmask_i;
      end else begin
        exp_addr = imem_addr_i & ~32'h3;
        exp_wm = 4'h0;
        exp_rm = imem_rmask_i;
      end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      n_cmp++;
      if (grant_o !== (pick_d ? 2'b10 : 2'b01) || mem_addr_o !== exp_addr || mem_rmask_o !== exp_rm ||
          mem_wmask_o !== exp_wm || (pick_d && exp_wm != 0 && mem_wdata_o !== dmem_wdata_i)) begin
        n_err++; $display("FAIL rand_issue t=%0d grant=%b addr=%h rm=%h wm=%h want d=%0d addr=%h rm=%h wm=%h",
                          t, grant_o, mem_addr_o, mem_rmask_o, mem_wmask_o, pick_d, exp_addr, exp_rm, exp_wm);
      end
      lat = $urandom_range(0, 2);
      for (int k = 0; k < lat; k++) begin
        #1;
        n_cmp++;
        if (imem_resp_o !== 1'b0 || dmem_resp_o !== 1'b0) begin
          n_err++; $display("FAIL rand_wait t=%0d iresp=%b dresp=%b want 0/0", t, imem_resp_o, dmem_resp_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (grant_o !== (pick_d ? 2'b10 : 2'b01) || mem_addr_o !== exp_addr) begin
          n_err++; $display("FAIL rand_hold t=%0d grant=%b addr=%h want addr=%h", t, grant_o, mem_addr_o, exp_addr);
        end
      end
      rd = $urandom;
      mem_resp_i = 1'b1; mem_rdata_i = rd;
      #1;
      n_cmp++;
      if (pick_d ? (dmem_resp_o !== 1'b1 || dmem_rdata_o !== rd || imem_resp_o !== 1'b0 || imem_rdata_o !== 32'h0)
                 : (imem_resp_o !== 1'b1 || imem_rdata_o !== rd || dmem_resp_o !== 1'b0 || dmem_rdata_o !== 32'h0)) begin
        n_err++; $display("FAIL rand_resp t=%0d d=%0d iresp=%b irdata=%h dresp=%b drdata=%h rdata=%h", t, pick_d,
                          imem_resp_o, imem_rdata_o, dmem_resp_o, dmem_rdata_o, rd);
      end
      if (pick_d) begin
        if (i_pend) begin
          cnt_m = (cnt_m < STARVE_MAX) ? cnt_m + 1 : STARVE_MAX;
          i_wait++;
        end
        last_d = 1;
      end else begin
`ifndef MEM_ARB_RR_EN
        n_cmp++;
        if (i_wait > STARVE_MAX) begin
          n_err++; $display("FAIL rand_starve t=%0d waited=%0d limit=%0d", t, i_wait, STARVE_MAX);
        end
`endif
        cnt_m = 0; i_wait = 0; last_d = 0;
      end
      @(posedge clk_i); #1;
      mem_resp_i = 1'b0;
      if (pick_d) begin
        d_pend = 0; dmem_rmask_i = 0; dmem_wmask_i = 0;
      end else begin
        i_pend = 0; imem_rmask_i = 0;
      end
    end
    clear_inputs();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_lone_fetch();
    test_store_byte();
    test_spurious_resp();
    test_contention();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
